// File: rtl/video_tap_pkg.sv
// Shared constants and helpers for the video line tap.
package video_tap_pkg;

   localparam int TAPS_MAX = 16;

   // Top-edge fill modes for slots above the first line of a frame.
   localparam logic BORDER_ZERO = 1'b0;
   localparam logic BORDER_REPL = 1'b1;

   // Width of wr_ptr / lines_seen; never narrower than one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Line RAM holding the line k rows above the current one.
   // Requires wr_ptr < taps-1 and 1 <= k <= taps-1.
   function automatic int slot_idx(
      input int wr_ptr,
      input int k,
      input int taps
   );
      int d;
      d = wr_ptr - k;
      if (d < 0) d = d + (taps - 1);
      return d;
   endfunction

endpackage

// File: rtl/video_tap_line_ram.sv
// One line buffer: read-first RAM, 1-cycle read latency.
module video_tap_line_ram #(
   parameter int DSIZE = 10,
   parameter int ASIZE = 11
) (
   input  logic             clock,
   input  logic             we,
   input  logic [ASIZE-1:0] addr,
   input  logic [DSIZE-1:0] wdata,
   output logic [DSIZE-1:0] rdata
);

   logic [DSIZE-1:0] mem [2**ASIZE];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/video_line_tap.sv
// Vertical TAPS-line window generator over streaming pixels.
// Build option VIDEO_LINE_TAP_REPLICATE_EN: top-edge replicate fill.
module video_line_tap
   import video_tap_pkg::*;
#(
   parameter int TAPS  = 3,
   parameter int DSIZE = 10,
   parameter int ASIZE = 11
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DSIZE-1:0]      in_data,
   input  logic                  in_sof,
   input  logic                  in_eol,
   output logic                  out_valid,
   output logic [TAPS*DSIZE-1:0] out_data,
   output logic                  out_sof,
   output logic                  out_eol,
   output logic                  err_ovf
);

   localparam int PW   = clog2(TAPS);
   localparam int NRAM = TAPS - 1;
   localparam logic [ASIZE-1:0] COL_MAX = '1;
   localparam logic [PW-1:0]    WR_LAST = PW'(TAPS - 2);
   localparam logic [PW-1:0]    LS_MAX  = PW'(TAPS - 1);

`ifdef VIDEO_LINE_TAP_REPLICATE_EN
   localparam logic BORDER = BORDER_REPL;
`else
   localparam logic BORDER = BORDER_ZERO;
`endif

   logic [ASIZE-1:0] col_addr;
   logic [ASIZE-1:0] col_eff;
   logic [ASIZE-1:0] col_nxt;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    wr_eff;
   logic [PW-1:0]    wr_nxt;
   logic [PW-1:0]    lines_seen;
   logic [PW-1:0]    ls_eff;
   logic [PW-1:0]    ls_nxt;
   logic             sof_eff;
   logic             err_nxt;

   // Frame start overrides the counters before this pixel is used.
   always_comb begin
      sof_eff = in_valid & in_sof;
      col_eff = sof_eff ? '0 : col_addr;
      wr_eff  = sof_eff ? '0 : wr_ptr;
      ls_eff  = sof_eff ? '0 : lines_seen;
      err_nxt = sof_eff ? 1'b0 : err_ovf;
      col_nxt = col_eff;
      wr_nxt  = wr_eff;
      ls_nxt  = ls_eff;
      if (in_eol) begin
         col_nxt = '0;
         wr_nxt  = (wr_eff == WR_LAST) ? '0 : wr_eff + 1'b1;
         ls_nxt  = (ls_eff == LS_MAX) ? ls_eff : ls_eff + 1'b1;
      end else if (col_eff == COL_MAX) begin
         err_nxt = 1'b1;
      end else begin
         col_nxt = col_eff + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         col_addr   <= '0;
         wr_ptr     <= '0;
         lines_seen <= '0;
         err_ovf    <= 1'b0;
      end else if (in_valid) begin
         col_addr   <= col_nxt;
         wr_ptr     <= wr_nxt;
         lines_seen <= ls_nxt;
         err_ovf    <= err_nxt;
      end
   end

   logic [DSIZE-1:0] rdata [NRAM];

   for (genvar g = 0; g < NRAM; g++) begin : g_ram
      video_tap_line_ram #(
         .DSIZE(DSIZE),
         .ASIZE(ASIZE)
      ) u_ram (
         .clock(clock),
         .we   (in_valid && (wr_eff == PW'(g))),
         .addr (col_eff),
         .wdata(in_data),
         .rdata(rdata[g])
      );
   end

   // Stage 1: aligned with RAM read data.
   logic             v1;
   logic             sof1;
   logic             eol1;
   logic [DSIZE-1:0] d1;
   logic [PW-1:0]    wr1;
   logic [PW-1:0]    ls1;

   always_ff @(posedge clock) begin
      if (rst) begin
         v1   <= 1'b0;
         sof1 <= 1'b0;
         eol1 <= 1'b0;
         d1   <= '0;
         wr1  <= '0;
         ls1  <= '0;
      end else begin
         v1   <= in_valid;
         sof1 <= sof_eff;
         eol1 <= in_valid & in_eol;
         if (in_valid) begin
            d1  <= in_data;
            wr1 <= wr_eff;
            ls1 <= ls_eff;
         end
      end
   end

   logic [DSIZE-1:0]      slot [TAPS];
   logic [DSIZE-1:0]      repl;
   logic [TAPS*DSIZE-1:0] col_data;
   int                    sel;

   always_comb begin
      sel     = 0;
      slot[0] = d1;
      for (int k = 1; k < TAPS; k++) begin
         sel     = slot_idx(int'(wr1), k, TAPS);
         slot[k] = '0;
         for (int j = 0; j < NRAM; j++) begin
            if (sel == j) slot[k] = rdata[j];
         end
      end
      repl = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (ls1 == PW'(k)) repl = slot[k];
      end
      // Slots above the frame's first line are border-filled.
      col_data = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (k <= int'(ls1)) begin
            col_data[k*DSIZE +: DSIZE] = slot[k];
         end else if (BORDER == BORDER_REPL) begin
            col_data[k*DSIZE +: DSIZE] = repl;
         end
      end
   end

   // Stage 2: output register.
   always_ff @(posedge clock) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= v1;
         out_sof   <= sof1;
         out_eol   <= eol1;
         out_data  <= v1 ? col_data : '0;
      end
   end

endmodule

// File: tb/tb_video_line_tap.sv
// Scoreboard bench for video_line_tap against a line-history model.
module tb_video_line_tap;

   localparam int TAPS  = 5;
   localparam int DSIZE = 10;
   localparam int ASIZE = 3;
   localparam int W     = TAPS * DSIZE;
   localparam int MAXC  = (1 << ASIZE) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [DSIZE-1:0] in_data = '0;
   logic             in_sof = 1'b0;
   logic             in_eol = 1'b0;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_sof;
   logic             out_eol;
   logic             err_ovf;

   video_line_tap #(
      .TAPS (TAPS),
      .DSIZE(DSIZE),
      .ASIZE(ASIZE)
   ) dut (
      .clock    (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_sof   (in_sof),
      .in_eol   (in_eol),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_sof  (out_sof),
      .out_eol  (out_eol),
      .err_ovf  (err_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] data;
      logic         sof;
      logic         eol;
      int           cyc;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic chk(input string n, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end else begin
         passed++;
      end
   endtask

   // Reference: pixels of the current frame indexed by line and column.
   int hist [64][8];
   int m_ln  = 0;
   int m_col = 0;
   bit m_err = 0;

   task automatic model_pixel(input int d, input bit s, input bit e,
                              output logic [W-1:0] exp);
      int lsn;
      int v;
      int top;
      if (s) begin
         m_ln  = 0;
         m_col = 0;
         m_err = 0;
      end
      hist[m_ln][m_col] = d;
      lsn = (m_ln < TAPS - 1) ? m_ln : TAPS - 1;
      top = (lsn == 0) ? d : hist[m_ln - lsn][m_col];
      exp = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (k == 0) v = d;
         else if (k <= lsn) v = hist[m_ln - k][m_col];
`ifdef VIDEO_LINE_TAP_REPLICATE_EN
         else v = top;
`else
         else v = 0;
`endif
         exp[k*DSIZE +: DSIZE] = DSIZE'(v);
      end
      if (e) begin
         if (m_ln < 63) m_ln++;
         m_col = 0;
      end else if (m_col == MAXC) begin
         m_err = 1;
      end else begin
         m_col++;
      end
   endtask

   task automatic px(input bit v, input int d, input bit s, input bit e);
      exp_t x;
      @(negedge clk);
      in_valid = v;
      in_data  = DSIZE'(d);
      in_sof   = s;
      in_eol   = e;
      if (v) begin
         model_pixel(d, s, e, x.data);
         x.sof = s;
         x.eol = e;
         x.cyc = cyc + 2;
         q.push_back(x);
      end
      @(posedge clk);
      #1;
      chk("err_ovf", 64'(err_ovf), 64'(m_err));
   endtask

   task automatic idle(input int n);
      repeat (n) px(0, $urandom_range(0, 1023), 1'($urandom),
                    1'($urandom));
   endtask

   task automatic frame(input int lines, input int len, input bit gaps,
                        input bit ramp);
      int d;
      for (int l = 0; l < lines; l++) begin
         for (int c = 0; c < len; c++) begin
            if (gaps) idle($urandom_range(0, 1) * $urandom_range(1, 2));
            d = ramp ? l * 16 + c : $urandom_range(0, 1023);
            px(1, d, (l == 0) && (c == 0), c == len - 1);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_data"}, 64'(out_data), 64'(0));
      chk({tag, "_sof"}, 64'(out_sof), 64'(0));
      chk({tag, "_eol"}, 64'(out_eol), 64'(0));
      chk({tag, "_err"}, 64'(err_ovf), 64'(0));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      m_ln  = 0;
      m_col = 0;
      m_err = 0;
      @(negedge clk);
      check_idle_outputs("rst");
      rst = 1'b0;
   endtask

   // Monitor: pops one expectation per presented column.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_out: got valid data %h, none due",
                        out_data);
            end else begin
               x = q.pop_front();
               chk("data", 64'(out_data), 64'(x.data));
               chk("sof", 64'(out_sof), 64'(x.sof));
               chk("eol", 64'(out_eol), 64'(x.eol));
               chk("latency_cyc", 64'(cyc), 64'(x.cyc));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // Ramp frame: ordering and top border.
      frame(3, 4, 0, 1);
      idle(3);

      // Gapped frame exercising full pointer rotation.
      frame(8, 7, 1, 0);
      idle(2);

      // Overflow: 10 pixels without eol, then sof clears it.
      for (int i = 0; i < 10; i++) px(1, 100 + i, i == 0, 0);
      px(1, 55, 1, 1);
      idle(2);

      // Reset mid-line, then a fresh frame.
      frame(1, 1, 0, 0);
      px(1, 11, 1, 0);
      px(1, 12, 0, 0);
      px(1, 13, 0, 0);
      pulse_reset();
      frame(3, 5, 0, 0);
      idle(2);

      // Random frames, including single-pixel and full-length lines.
      for (int f = 0; f < 6; f++) begin
         frame($urandom_range(1, 10), $urandom_range(1, MAXC + 1), 1, 0);
         idle($urandom_range(0, 3));
      end
      frame(4, MAXC + 1, 0, 0);

      idle(4);
      chk("pending", 64'(q.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
